// File: rtl/dcache_arbiter_pkg.sv
// Shared constants and types for the data-cache port arbiter.
// Compile with DCACHE_ARB_RR_EN defined to get round-robin grant instead of fixed priority.
package dcache_arb_pkg;

  localparam int DEF_NREQ  = 3;
  localparam int DEF_WIDTH = 12;
  localparam int DEF_TAGW  = 6;
  localparam int DEF_IDW   = $clog2(DEF_NREQ);

  localparam int REQ_LOAD  = 0;
  localparam int REQ_STORE = 1;
  localparam int REQ_AUX   = 2;

  typedef struct packed {
    logic                 we;
    logic                 load;
    logic [DEF_IDW-1:0]   id;
    logic [DEF_TAGW-1:0]  tag;
    logic [DEF_WIDTH-1:0] addr;
    logic [31:0]          data;
  } port_stage_t;

endpackage

// File: rtl/dcache_arbiter_if.sv
// Requester, cache-port and load-response bundle of the data-cache arbiter.
// master = requesters plus cache side, slave = the arbiter itself.
interface dcache_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 12,
  parameter int TAGW  = 6
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ-1:0]       o_req_ready;
  logic [NREQ-1:0]       i_req_we;
  logic [NREQ*WIDTH-1:0] i_req_addr;
  logic [NREQ*32-1:0]    i_req_data;
  logic [NREQ*TAGW-1:0]  i_req_tag;
  logic                  i_flush;
  logic                  o_we;
  logic [WIDTH-1:0]      o_DcacheAddr;
  logic [31:0]           o_data;
  logic [31:0]           i_DcacheData;
  logic                  o_resp_valid;
  logic [IDW-1:0]        o_resp_id;
  logic [TAGW-1:0]       o_resp_tag;
  logic [31:0]           o_resp_data;

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_data, i_req_tag, i_flush, i_DcacheData,
    input  o_req_ready, o_we, o_DcacheAddr, o_data,
    input  o_resp_valid, o_resp_id, o_resp_tag, o_resp_data
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_data, i_req_tag, i_flush, i_DcacheData,
    output o_req_ready, o_we, o_DcacheAddr, o_data,
    output o_resp_valid, o_resp_id, o_resp_tag, o_resp_data
  );

endinterface

// File: rtl/dcache_arbiter_rr_pick.sv
// Combinational one-hot priority picker; the search starts at i_ptr and wraps mod NREQ.
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_gnt_idx,
  output logic                    o_any
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW:0] slot;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    slot      = '0;
    for (int i = 0; i < NREQ; i++) begin
      // One extra bit so ptr+i can be folded back below NREQ for non-power-of-two sizes.
      slot = {1'b0, i_ptr} + (IDW+1)'(i);
      if (slot >= (IDW+1)'(NREQ)) slot = slot - (IDW+1)'(NREQ);
      if (!o_any && i_req[slot[IDW-1:0]]) begin
        o_gnt[slot[IDW-1:0]] = 1'b1;
        o_gnt_idx            = slot[IDW-1:0];
        o_any                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_arbiter.sv
// Data-cache port arbiter: grant, port stage (P), response stage (R) and flush gating.
// DCACHE_ARB_RR_EN selects round-robin grant; otherwise the lowest index wins.
module dcache_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAGW  = DEF_TAGW
) (
  input  logic           i_clk,
  input  logic           i_rst,
  dcache_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr;
  logic            gnt_any;

  port_stage_t     p_d, p_q;
  logic            resp_valid_d, resp_valid_q;
  logic [IDW-1:0]  resp_id_d, resp_id_q;
  logic [TAGW-1:0] resp_tag_d, resp_tag_q;
  logic [31:0]     resp_data_d, resp_data_q;

  // Loads are held off during flush; nothing is accepted while reset is applied.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = bus.i_req_valid[k] && !(bus.i_flush && !bus.i_req_we[k]) && !i_rst;
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (elig),
    .i_ptr    (ptr),
    .o_gnt    (gnt),
    .o_gnt_idx(gnt_idx),
    .o_any    (gnt_any)
  );

  assign bus.o_req_ready = gnt;

`ifdef DCACHE_ARB_RR_EN
  logic [IDW-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Idle cycles keep address and data so the cache port does not toggle needlessly.
  always_comb begin
    p_d      = p_q;
    p_d.we   = 1'b0;
    p_d.load = 1'b0;
    if (gnt_any) begin
      p_d.we   = bus.i_req_we[gnt_idx];
      p_d.load = !bus.i_req_we[gnt_idx];
      p_d.id   = gnt_idx;
      p_d.tag  = bus.i_req_tag[gnt_idx*TAGW +: TAGW];
      p_d.addr = bus.i_req_addr[gnt_idx*WIDTH +: WIDTH];
      p_d.data = bus.i_req_data[gnt_idx*32 +: 32];
    end
  end

  always_comb begin
    resp_valid_d = p_q.load && !bus.i_flush;
    resp_id_d    = resp_id_q;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    if (resp_valid_d) begin
      resp_id_d   = p_q.id;
      resp_tag_d  = p_q.tag;
      resp_data_d = bus.i_DcacheData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      p_q          <= p_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.o_we         = p_q.we;
  assign bus.o_DcacheAddr = p_q.addr;
  assign bus.o_data       = p_q.data;
  assign bus.o_resp_valid = resp_valid_q;
  assign bus.o_resp_id    = resp_id_q;
  assign bus.o_resp_tag   = resp_tag_q;
  assign bus.o_resp_data  = resp_data_q;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter: expected load responses go into a queue that a
// negedge monitor drains whenever o_resp_valid is high; port and grant values are checked inline.
module tb_dcache_arbiter;
  import dcache_arb_pkg::*;

  localparam int NREQ  = DEF_NREQ;
  localparam int WIDTH = DEF_WIDTH;
  localparam int TAGW  = DEF_TAGW;

  typedef struct packed {
    logic [1:0]  id;
    logic [5:0]  tag;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .TAGW(TAGW)) bus ();

  dcache_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  logic [31:0] mem [0:4095];
  assign bus.i_DcacheData = mem[bus.o_DcacheAddr];
  always @(posedge clk) if (bus.o_we) mem[bus.o_DcacheAddr] <= bus.o_data;

  resp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (bus.o_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual id=%0d tag=%0d data=%h expected=no response",
                 bus.o_resp_id, bus.o_resp_tag, bus.o_resp_data);
      end else begin
        e = exp_q.pop_front();
        check("resp_id",   64'(bus.o_resp_id),   64'(e.id));
        check("resp_tag",  64'(bus.o_resp_tag),  64'(e.tag));
        check("resp_data", 64'(bus.o_resp_data), 64'(e.data));
      end
    end
  end

  task automatic clr_req();
    bus.i_req_valid = '0;
    bus.i_req_we    = '0;
    bus.i_flush     = 1'b0;
  endtask

  task automatic set_req(input int k, input logic we, input logic [WIDTH-1:0] addr,
                         input logic [31:0] data, input logic [TAGW-1:0] tag);
    bus.i_req_valid[k]               = 1'b1;
    bus.i_req_we[k]                  = we;
    bus.i_req_addr[k*WIDTH +: WIDTH] = addr;
    bus.i_req_data[k*32 +: 32]       = data;
    bus.i_req_tag[k*TAGW +: TAGW]    = tag;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [5:0] tag, input logic [31:0] data);
    resp_t e;
    e.id   = id;
    e.tag  = tag;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_we"},        64'(bus.o_we),         64'd0);
    check({pfx, "_addr"},      64'(bus.o_DcacheAddr), 64'd0);
    check({pfx, "_data"},      64'(bus.o_data),       64'd0);
    check({pfx, "_rvalid"},    64'(bus.o_resp_valid), 64'd0);
    check({pfx, "_rid"},       64'(bus.o_resp_id),    64'd0);
    check({pfx, "_rtag"},      64'(bus.o_resp_tag),   64'd0);
    check({pfx, "_rdata"},     64'(bus.o_resp_data),  64'd0);
  endtask

  initial begin
    int exp_g;
    rst            = 1'b1;
    bus.i_req_addr = '0;
    bus.i_req_data = '0;
    bus.i_req_tag  = '0;
    clr_req();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h030] = 32'h30303030;
    mem[12'h050] = 32'h50505050;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // single load
    set_req(0, 1'b0, 12'h010, 32'h0, 6'd5);
    #1 check("load_ready", 64'(bus.o_req_ready), 64'b001);
    push_exp(2'd0, 6'd5, 32'hDEADBEEF);
    @(negedge clk);
    clr_req();
    check("load_port_addr", 64'(bus.o_DcacheAddr), 64'h010);
    check("load_port_we",   64'(bus.o_we),         64'd0);
    repeat (3) @(negedge clk);

    // contention from a freshly reset pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b0, 12'h030, 32'h0,        6'd1);
    set_req(1, 1'b1, 12'h040, 32'hA5A50001, 6'd0);
    set_req(2, 1'b0, 12'h050, 32'h0,        6'd2);
    for (int c = 0; c < 6; c++) begin
`ifdef DCACHE_ARB_RR_EN
      exp_g = c % 3;
`else
      exp_g = 0;
`endif
      #1 check("contend_grant", 64'(bus.o_req_ready), 64'(1 << exp_g));
      if (exp_g == 0) push_exp(2'd0, 6'd1, 32'h30303030);
      if (exp_g == 2) push_exp(2'd2, 6'd2, 32'h50505050);
      @(negedge clk);
    end
    clr_req();
    repeat (3) @(negedge clk);

    // store then load to the same address
    set_req(1, 1'b1, 12'h020, 32'h12345678, 6'd0);
    #1 check("st_ready", 64'(bus.o_req_ready), 64'b010);
    @(negedge clk);
    clr_req();
    set_req(0, 1'b0, 12'h020, 32'h0, 6'd7);
    #1 check("ld_after_st_ready", 64'(bus.o_req_ready), 64'b001);
    check("st_port_we",   64'(bus.o_we),         64'd1);
    check("st_port_addr", 64'(bus.o_DcacheAddr), 64'h020);
    check("st_port_data", 64'(bus.o_data),       64'h12345678);
    push_exp(2'd0, 6'd7, 32'h12345678);
    @(negedge clk);
    clr_req();
    repeat (3) @(negedge clk);

    // flush kills the load in P and blocks new loads, stores still go
    set_req(0, 1'b0, 12'h010, 32'h0, 6'd3);
    #1 check("fl_load_ready", 64'(bus.o_req_ready), 64'b001);
    @(negedge clk);
    clr_req();
    bus.i_flush = 1'b1;
    set_req(0, 1'b0, 12'h010, 32'h0,  6'd4);
    set_req(1, 1'b1, 12'h060, 32'h66, 6'd0);
    #1 check("fl_ready", 64'(bus.o_req_ready), 64'b010);
    @(negedge clk);
    clr_req();
    check("fl_no_resp",  64'(bus.o_resp_valid), 64'd0);
    check("fl_store_we", 64'(bus.o_we),         64'd1);
    repeat (2) @(negedge clk);

    // a response already in R survives a flush in that cycle
    set_req(0, 1'b0, 12'h010, 32'h0, 6'd6);
    #1 check("flr_ready", 64'(bus.o_req_ready), 64'b001);
    push_exp(2'd0, 6'd6, 32'hDEADBEEF);
    @(negedge clk);
    clr_req();
    @(negedge clk);
    check("flr_resp_present", 64'(bus.o_resp_valid), 64'd1);
    bus.i_flush = 1'b1;
    @(negedge clk);
    clr_req();
    repeat (2) @(negedge clk);

    // reset while a load is in flight
    set_req(0, 1'b0, 12'h010, 32'h0, 6'd9);
    #1 check("rst_load_ready", 64'(bus.o_req_ready), 64'b001);
    @(negedge clk);
    clr_req();
    rst = 1'b1;
    set_req(0, 1'b0, 12'h030, 32'h0,        6'd1);
    set_req(1, 1'b1, 12'h040, 32'hA5A50001, 6'd0);
    set_req(2, 1'b0, 12'h050, 32'h0,        6'd2);
    #1 check("ready_in_reset", 64'(bus.o_req_ready), 64'b000);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    #1 check("post_rst_grant", 64'(bus.o_req_ready), 64'b001);
    push_exp(2'd0, 6'd1, 32'h30303030);
    @(negedge clk);
    clr_req();
    repeat (4) @(negedge clk);

    check("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_arbiter.md
# dcache_arbiter

Shares the single data-cache port (o_we / o_DcacheAddr / o_data / i_DcacheData) of the out-of-order core among several memory requesters: the load pipe behind MemCalc, the committed-store drain from the ROB, and one auxiliary port for debug or a future prefetcher. Each cycle it grants at most one valid/ready request and registers it onto the cache port. Load data returns to the requester one cycle later, tagged with its ROB tag. A pipeline flush kills in-flight loads; committed stores are never dropped.

## Interface
- WIDTH, 12, data-cache address width
- NREQ, 3, number of requesters (index 0 load, 1 store, 2 aux)
- TAGW, 6, ROB tag width carried with loads
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req_valid  in  NREQ  request valid per requester
- o_req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- i_req_we  in  NREQ  1 = store, 0 = load
- i_req_addr  in  NREQ*WIDTH  addresses, requester k at bits [k*WIDTH +: WIDTH]
- i_req_data  in  NREQ*32  store data
- i_req_tag  in  NREQ*TAGW  ROB tag
- i_flush  in  1  branch-mispredict / exception flush
- o_we  out  1  cache write enable
- o_DcacheAddr  out  WIDTH  cache address
- o_data  out  32  cache write data
- i_DcacheData  in  32  cache read data, combinational on o_DcacheAddr
- o_resp_valid  out  1  load response valid
- o_resp_id  out  $clog2(NREQ)  requester receiving the response
- o_resp_tag  out  TAGW  ROB tag of the response
- o_resp_data  out  32  load data

## Operation
- Grant: in each cycle, pick one eligible requester, where eligible means valid and not a blocked load (see Flush). o_req_ready is high for the winner only. Ready depends combinationally on valid; requesters must not make valid depend on ready.
- Port stage (P): the accepted request is registered into o_we, o_DcacheAddr, o_data, plus the internal p_load, p_id and p_tag.
  - Idle cycle: o_we = 0 and p_load = 0; address and data hold their previous values.
- Response stage (R): if p_load is set and not killed, i_DcacheData, p_id and p_tag are registered into the o_resp_* outputs with o_resp_valid = 1. Otherwise o_resp_valid = 0.
- Stores produce no response.
- Flush, in the cycle i_flush = 1:
  - load requests are ineligible (ready = 0); store requests are still granted;
  - a load in P is killed, so no response appears next cycle;
  - a response already in R this cycle is still presented, and requesters discard it by tag.
- Ordering: requests reach the cache strictly in grant order. A store in P followed by a load in the next grant sees the stored data.
- Reset: o_we = 0, o_DcacheAddr = 0, o_data = 0, o_resp_valid = 0, o_resp_id = 0, o_resp_tag = 0, o_resp_data = 0. The internal p_load is cleared and the RR pointer is set to 0.
  - Reset wins over flush and requests in the same cycle.
  - Reset asserted mid-operation drops the P and R contents without issuing a response.

## Timing
- A request accepted in cycle t (ready = 1) drives the cache port in cycle t+1.
- A load accepted in cycle t has o_resp_valid in cycle t+2.
- Throughput is one request per cycle, and back-to-back grants to the same requester are allowed.
- Flush in cycle t kills a load accepted in cycle t-1. A load accepted in cycle t-2 still responds in cycle t.

## Configuration
- DCACHE_ARB_RR_EN defined:
  - round-robin grant. A pointer ptr names the highest-priority requester, and the search order is ptr, ptr+1, …, wrapping mod NREQ.
  - After a grant to g, ptr = (g+1) mod NREQ. With no grant, ptr holds. ptr resets to 0.
- DCACHE_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register exists, so a load can starve store drain.

## Structure
- Package dcache_arb_pkg holds:
  - default NREQ, WIDTH and TAGW;
  - requester indices REQ_LOAD = 0, REQ_STORE = 1, REQ_AUX = 2;
  - a port-stage struct {we, load, id, tag, addr, data}.
- One sub-module, rr_pick: an NREQ-wide one-hot priority picker with a rotate-by-ptr input (ptr tied to 0 in fixed mode). It is combinational.
- The arbiter top holds the P and R registers, the pointer and the flush gating.

## Test plan
- Single load: req 0 sends addr 0x010 with tag 5 at t0, and the cache returns 0xDEADBEEF.
  - Expect ready[0] at t0; o_DcacheAddr = 0x010 and o_we = 0 at t1.
  - Expect resp valid at t2 with id 0, tag 5, data 0xDEADBEEF.
- Contention, RR_EN: all three requesters valid for 6 cycles.
  - Grants must be 0, 1, 2, 0, 1, 2.
  - Without RR_EN, all six grants go to 0.
- Store then load: a store of 0x12345678 to 0x020 is accepted at t0, and a load of 0x020 at t1.
  - Expect o_we = 1 at t1.
  - Expect load resp at t3 with data 0x12345678.
- Flush: load tag 3 accepted at t0, then i_flush at t1 with req 0 (load) and req 1 (store) valid.
  - No response at t2.
  - ready[1] = 1 and ready[0] = 0 at t1.
- Reset mid-flight: load accepted at t0, i_rst at t1.
  - Expect o_resp_valid = 0 at t2, and all outputs at their reset values.
  - With RR_EN, the first grant after reset goes to requester 0.
